// File: rtl/reg_xfer_sequencer.sv
// reg_xfer_sequencer: multi-cycle register-transfer sequencer.
// Accepts LOAD / MOVE / SWAP commands and walks through the bus phases,
// driving one-hot register read/write selects and temp-register controls.
// Outputs are Moore (state + latched fields) and gated by the step enable.
module reg_xfer_sequencer #(
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      dst,
  input  logic [SEL_W-1:0]      src,
  output logic [(2**SEL_W)-1:0] rd_sel,
  output logic [(2**SEL_W)-1:0] wr_sel,
  output logic                  ext_oe,
  output logic                  tmp_ld,
  output logic                  tmp_oe,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NREG = 2**SEL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_MV_RD,
    S_MV_WR,
    S_SW_T,
    S_SW_A,
    S_SW_B,
    S_BAD
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_mode;
  logic [SEL_W-1:0]  r_dst;
  logic [SEL_W-1:0]  r_src;
  logic              w_accept;
  logic [NREG-1:0]   w_dst_oh;
  logic [NREG-1:0]   w_src_oh;

  assign w_accept = (r_state == S_IDLE) && en && start;
  assign w_dst_oh = {{(NREG-1){1'b0}}, 1'b1} << r_dst;
  assign w_src_oh = {{(NREG-1){1'b0}}, 1'b1} << r_src;

  // State register and command field latch (captured only on acceptance).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= '0;
      r_dst   <= '0;
      r_src   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode <= mode;
        r_dst  <= dst;
        r_src  <= src;
      end
    end
  end

  // Next-state logic; every transition requires en=1 (en=0 holds state).
  always_comb begin
    w_next = r_state;
    if (en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (mode)
              2'b00:   w_next = S_LD;
              2'b01:   w_next = S_MV_RD;
              2'b10:   w_next = S_SW_T;
              default: w_next = S_BAD;
            endcase
          end
        end
        S_LD:    w_next = S_IDLE;
        S_MV_RD: w_next = S_MV_WR;
        S_MV_WR: w_next = S_IDLE;
        S_SW_T:  w_next = S_SW_A;
        S_SW_A:  w_next = S_SW_B;
        S_SW_B:  w_next = S_IDLE;
        S_BAD:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Moore strobe decode from state and latched indices, forced off on stall.
  always_comb begin
    rd_sel = '0;
    wr_sel = '0;
    ext_oe = 1'b0;
    tmp_ld = 1'b0;
    tmp_oe = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    busy   = (r_state != S_IDLE);
    if (en) begin
      case (r_state)
        S_LD: begin
          wr_sel = w_dst_oh;
          ext_oe = 1'b1;
          done   = 1'b1;
        end
        S_MV_RD: begin
          rd_sel = w_src_oh;
          tmp_ld = 1'b1;
        end
        S_MV_WR: begin
          tmp_oe = 1'b1;
          wr_sel = w_dst_oh;
          done   = 1'b1;
        end
        S_SW_T: begin
          rd_sel = w_src_oh;
          tmp_ld = 1'b1;
        end
        S_SW_A: begin
          rd_sel = w_dst_oh;
          wr_sel = w_src_oh;
        end
        S_SW_B: begin
          tmp_oe = 1'b1;
          wr_sel = w_dst_oh;
          done   = 1'b1;
        end
        S_BAD: begin
          err  = 1'b1;
          done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // r_mode is retained as part of the latched command context.
  logic w_unused_mode;
  assign w_unused_mode = ^r_mode;

endmodule
